// File: rtl/pdm_decimator.sv
// PDM-to-PCM converter: two-flop input synchronizer followed by a 3rd-order CIC
// decimator (integrators at bit rate, combs at sample rate) with warm-up suppression.
module pdm_decimator #(
    parameter int unsigned BITDEPTH   = 12,
    parameter int unsigned DECIMATION = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in,
    input  logic                bit_en,
    output logic [BITDEPTH-1:0] pcm,
    output logic                pcm_valid
);

    localparam int unsigned L = $clog2(DECIMATION);
    localparam int unsigned W = 3 * L + 1;
    localparam logic [W-1:0] FullScale = W'(1) << (3 * L);

    logic         s1, s2;
    logic [W-1:0] i1, i2, i3;
    logic [W-1:0] i1_d, i2_d, i3_d;
    logic [L-1:0] cnt;
    logic         tick, tick_q;
    logic [W-1:0] c1, c2, c3;
    logic [W-1:0] d1, d2, d3;
    logic         v1, v2, v3;
    logic [1:0]   warm;
    logic [BITDEPTH-1:0] pcm_d;

    assign tick = bit_en && (cnt == L'(DECIMATION - 1));

    always_comb begin
        i1_d = i1 + W'(s2);
        i2_d = i2 + i1_d;
        i3_d = i3 + i2_d;
    end

    // Comb result spans 0..2^(3L) inclusive; only the top value needs saturating.
    always_comb begin
        pcm_d = c3[3*L-1 -: BITDEPTH];
        if (c3 == FullScale) begin
            pcm_d = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            i1  <= '0;
            i2  <= '0;
            i3  <= '0;
            cnt <= '0;
        end else begin
            s1 <= in;
            s2 <= s1;
            if (bit_en) begin
                i1  <= i1_d;
                i2  <= i2_d;
                i3  <= i3_d;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Comb stages advance on their own valid bits, independent of bit_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            c1     <= '0;
            c2     <= '0;
            c3     <= '0;
            d1     <= '0;
            d2     <= '0;
            d3     <= '0;
        end else begin
            tick_q <= tick;
            v1     <= tick_q;
            v2     <= v1;
            v3     <= v2;
            if (tick_q) begin
                c1 <= i3 - d1;
                d1 <= i3;
            end
            if (v1) begin
                c2 <= c1 - d2;
                d2 <= c1;
            end
            if (v2) begin
                c3 <= c2 - d3;
                d3 <= c2;
            end
        end
    end

    // First two samples after reset are built on empty comb delays; drop them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm      <= '0;
            pcm       <= '0;
            pcm_valid <= 1'b0;
        end else begin
            pcm_valid <= v3 && (warm == 2'd2);
            if (v3 && (warm != 2'd2)) begin
                warm <= warm + 2'd1;
            end
            if (v3 && (warm == 2'd2)) begin
                pcm <= pcm_d;
            end
        end
    end

endmodule

// File: doc/pdm_decimator.md
# pdm_decimator

Receive-side counterpart of the audio sigma-delta DAC: converts a 1-bit pulse-density stream back into unsigned PCM samples. It is used for comparator-based audio input and PDM microphones, and for DAC loopback self-test. The block synchronizes the input bit and runs a 3rd-order CIC decimator (integrators at bit rate, combs at sample rate). It emits one BITDEPTH-bit sample per DECIMATION accepted bits, with a single-cycle valid strobe.

## Interface
- BITDEPTH, 12: output sample width; must be ≤ 3·log2(DECIMATION).
- DECIMATION, 64: bits per output sample; power of two, ≥ 8.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in  in  1  PDM bit from pin/comparator; asynchronous to clk.
- bit_en  in  1  qualifies one PDM bit this cycle; tie high for one bit per clk.
- pcm  out  BITDEPTH  unsigned sample; 0 = no ones, all-ones = all ones.
- pcm_valid  out  1  one-cycle strobe; pcm is new in the same cycle.

## Operation
- Define L = log2(DECIMATION) and W = 3·L + 1 (internal width).
- All integrator, comb and delay registers are W bits. They wrap modulo 2^W; no saturation inside the filter.
- Synchronizer: `in` passes through two flops (s1, s2). The filter consumes s2.
- Integrators: on each cycle with bit_en = 1:
  - i1 += s2 (0 or 1)
  - i2 += i1(new)
  - i3 += i2(new)
  - With bit_en = 0, nothing changes: integrators and counter hold.
- Decimation counter: L bits, increments on bit_en, wraps DECIMATION−1 → 0.
- Tick: a bit_en cycle with counter == DECIMATION−1.
- Comb pipeline: 3 registered stages, each y = x − x_prev with a 1-sample delay register. It advances once per tick, starting from i3 as it stands after the tick bit.
- Output mapping from comb result y, exact range 0..2^(3L):
  - y == 2^(3L) → pcm = all ones (saturate).
  - Otherwise pcm = y[3L−1 -: BITDEPTH] (truncate).
- Warm-up: a tick counter suppresses pcm_valid for the first 2 ticks after reset. From the 3rd tick on, every tick produces a pulse and the output is exact.
- Reset (rst_n low, any time, including mid-sample or mid-pipeline):
  - Clears synchronizer, integrators, counter, comb/delay registers, pipeline-valid bits and warm-up count.
  - Outputs: pcm = 0, pcm_valid = 0.
  - No partially computed sample is emitted after release.

## Timing
- Input latency: 2 clk through the synchronizer before a bit can enter i1.
- Tick at edge T (i3 updated with the last bit of the window):
  - comb1 registered at T+1, comb2 at T+2, comb3 at T+3.
  - pcm and pcm_valid registered at T+4; pcm_valid is high for exactly one cycle.
- pcm holds its value between strobes.
- Pulse spacing is DECIMATION bit_en cycles. With bit_en always high, one pulse every DECIMATION clk.
- Because DECIMATION ≥ 8 > pipeline depth, consecutive ticks never overlap in the pipeline.
- bit_en may drop at any time, including on the tick cycle. A bit_en = 0 cycle is not a tick. The comb pipeline continues regardless of bit_en once a tick has occurred.
- First pulse after reset release, bit_en held high: tick 3 at bit count 3·DECIMATION, so the pulse arrives about 3·DECIMATION + 6 clk after release.

## Test plan
- **All zeros.** `in` = 0, bit_en = 1, defaults, after reset → first pcm_valid ~198 clk after release with pcm = 0. Subsequent pulses exactly 64 clk apart, all pcm = 0.
- **All ones (saturation).** `in` = 1 → every valid sample pcm = 4095 (y = 2^18 saturates). No wrap artifacts; pcm is never 0.
- **Alternating 1010…** → every valid sample pcm = 2048. Pattern 1000 repeating → pcm = 1024.
- **Throttled bit rate.** bit_en high 1 cycle in 4, with the 1010 pattern applied only on enabled cycles → pcm = 2048. Pulses 256 clk apart; integrators are unchanged across disabled cycles.
- **Reset mid-operation.** Assert rst_n low for 3 clk at T+2 after a tick → pcm = 0 and pcm_valid = 0 immediately. No pulse at the would-be T+4. Warm-up restarts: the next pulse comes after 3 full windows.
- **Loopback.** DAC (BITDEPTH 12) fed constant 1000, its out driving `in`, same clk, bit_en = 1 → after warm-up every pcm within 1000 ± 64. Repeat with 3000 → 3000 ± 64.
